vga_view_addr_gen: RTL and testbench
====================================

// Module: vga_view_addr_gen
// PURPOSE
// - Parametrised successor of the screen address path: maps VGA raster counts (h_cnt/v_cnt) to a frame-buffer pixel address.
// - Adds integer upscale, wrap-around horizontal/vertical panning, half-image toggle and mirroring.
// - Sits between vga_controller and the block-RAM image store; output timing matches a 1-cycle-read BRAM.
// PARAMETERS
// - H_ACTIVE     640  visible pixels per line
// - V_ACTIVE     480  visible lines per frame
// - IMG_W        320  stored image width (pixels)
// - IMG_H        240  stored image height (lines)
// - SCALE_SH     1    upscale = 2**SCALE_SH (legal 0..2)
// - ADDR_W       17   pixel_addr width; IMG_W*IMG_H <= 2**ADDR_W
// - STEP_X       1    pan step per tick, horizontal (1..IMG_W-1)
// - STEP_Y       1    pan step per tick, vertical (1..IMG_H-1)
// - TICK_FRAMES  4    frames between scroll steps (>=1)
// PORTS
// - clk        in   1       pixel clock (25 MHz)
// - rst_n      in   1       asynchronous, active-low reset
// - h_cnt      in   10      raster column from vga_controller
// - v_cnt      in   10      raster line from vga_controller
// - valid      in   1       raster inside active area
// - mode       in   2       0 STATIC, 1 PAN_H, 2 PAN_V, 3 TOGGLE
// - run        in   1       1 = stepping enabled; 0 = offsets hold
// - hmir       in   1       horizontal mirror (MIRROR_EN only)
// - vmir       in   1       vertical mirror (MIRROR_EN only)
// - pixel_addr out  ADDR_W  BRAM read address
// - pix_valid  out  1       valid delayed to align with BRAM data out
// - frame_tick out  1       1-cycle pulse at each frame boundary
// BEHAVIOUR
// - Reset: pixel_addr=0, pix_valid=0, frame_tick=0, off_x=off_y=0, frame_cnt=0, state=S_STATIC.
// - Frame boundary fb = (h_cnt==0 && v_cnt==V_ACTIVE), in vertical blanking; frame_tick=fb registered (1 cycle later).
// - FSM S_STATIC/S_PAN_H/S_PAN_V/S_TOGGLE; mode sampled only on fb (state<=mode). Mode change clears off_x, off_y, frame_cnt in the same update.
// - Stepping on fb with run=1 and unchanged mode: frame_cnt counts 0..TICK_FRAMES-1; when it wraps to 0, step:
//   PAN_H: off_x<=(off_x+STEP_X)>=IMG_W ? off_x+STEP_X-IMG_W : off_x+STEP_X; PAN_V: same on off_y with IMG_H.
//   TOGGLE: off_x alternates 0 <-> IMG_W/2; off_y=0. STATIC: offsets 0.
// - run=0: frame_cnt and offsets hold; state still follows mode. Offsets never change mid-frame (no tearing).
// - Stage 1 (reg): sx=(h_cnt>>SCALE_SH)+off_x, minus IMG_W if >=IMG_W; sy likewise with v_cnt/off_y/IMG_H. Single conditional subtract suffices (both terms < IMG_W/IMG_H).
// - Mirror (MIRROR_EN): after wrap, sx=IMG_W-1-sx if hmir; sy=IMG_H-1-sy if vmir.
// - Stage 2 (reg): pixel_addr=sy*IMG_W+sx; if stage-1 valid=0 then pixel_addr=0.
// - Latency: raster count -> pixel_addr 2 cycles; pix_valid = valid delayed 3 cycles (2 + BRAM read).
// - Reset mid-frame: all state cleared asynchronously; first fb after release resumes normal operation.
// CONFIGURATION
// - `define VGA_VIEW_MIRROR_EN: hmir/vmir applied as above.
// - Without it: hmir/vmir ports kept but ignored; mirror logic not synthesised; addresses identical to hmir=vmir=0.
// STRUCTURE
// - Package vga_view_pkg: mode encodings (MODE_STATIC..MODE_TOGGLE), state typedef, default H_ACTIVE/V_ACTIVE/IMG_W/IMG_H constants.
// - Sub-module pan_offset_ctr (one per axis): wrap-around offset register with step, limit, clear, hold, toggle inputs.
// - Top: fb detect, mode FSM, frame_cnt, 2-stage address pipeline, pix_valid delay line.
// TESTING
// - Reset: rst_n=0 mid-line -> all outputs 0 immediately; release, STATIC, h=0,v=0 -> pixel_addr=0 two cycles later.
// - STATIC, SCALE_SH=1: h=639,v=479 -> pixel_addr=239*320+319=76799; h=2,v=2 -> 321; pix_valid 3 cycles after valid.
// - PAN_H, STEP_X=1, TICK_FRAMES=4, off_x=319: fourth fb -> off_x=0; h=0,v=0 -> 0 (wrap, no overshoot to 320).
// - TOGGLE: successive ticks off_x 0->160->0; h=0,v=0 -> 160 then 0; run=0 holds 160 across 10 frames.
// - Mode switch PAN_V->PAN_H mid-frame: offsets unchanged until fb; at fb off_x=off_y=0, frame_cnt=0.
// - MIRROR_EN, hmir=1,vmir=1: h=0,v=0 -> 76799; without macro same stimulus -> 0.

Source files
------------

// File: rtl/vga_view_pkg.sv
// rtl/vga_view_pkg.sv - shared mode encodings, FSM state type and default geometry for the VGA view address path
package vga_view_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int IMG_W_DEF    = 320;
    localparam int IMG_H_DEF    = 240;

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_PAN_H  = 2'd1;
    localparam logic [1:0] MODE_PAN_V  = 2'd2;
    localparam logic [1:0] MODE_TOGGLE = 2'd3;

    // State codes equal the mode codes so the FSM can load mode directly.
    typedef enum logic [1:0] {
        S_STATIC = 2'd0,
        S_PAN_H  = 2'd1,
        S_PAN_V  = 2'd2,
        S_TOGGLE = 2'd3
    } state_t;

endpackage

// File: rtl/pan_offset_ctr.sv
// rtl/pan_offset_ctr.sv - one-axis wrap-around pan offset register with step, clear, hold and half-image toggle
module pan_offset_ctr #(
    parameter int LIMIT = 320,
    parameter int STEP  = 1,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         step,
    input  logic         tog,
    output logic [W-1:0] off
);

    localparam logic [W:0]   LIM   = (W+1)'(LIMIT);
    localparam logic [W:0]   INC   = (W+1)'(STEP);
    localparam logic [W-1:0] HALF  = W'(LIMIT / 2);

    logic [W:0] sum;

    // Both operands are below LIMIT, so one conditional subtract wraps exactly.
    assign sum = {1'b0, off} + INC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off <= '0;
        end else if (clr) begin
            off <= '0;
        end else if (step) begin
            off <= (sum >= LIM) ? W'(sum - LIM) : W'(sum);
        end else if (tog) begin
            off <= (off == '0) ? HALF : '0;
        end
    end

endmodule

// File: rtl/vga_view_addr_gen.sv
// rtl/vga_view_addr_gen.sv - raster to frame-buffer address with upscale, panning, toggle; `define VGA_VIEW_MIRROR_EN enables hmir/vmir
module vga_view_addr_gen
    import vga_view_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int IMG_W       = IMG_W_DEF,
    parameter int IMG_H       = IMG_H_DEF,
    parameter int SCALE_SH    = 1,
    parameter int ADDR_W      = 17,
    parameter int STEP_X      = 1,
    parameter int STEP_Y      = 1,
    parameter int TICK_FRAMES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic              valid,
    input  logic [1:0]        mode,
    input  logic              run,
    input  logic              hmir,
    input  logic              vmir,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              pix_valid,
    output logic              frame_tick
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int FW = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;

    logic          fb;
    logic          mode_chg;
    state_t        state;
    state_t        state_next;
    logic [FW-1:0] frame_cnt;
    logic          count_en;
    logic          wrap;
    logic          clr;
    logic          step_x;
    logic          step_y;
    logic          tog_x;
    logic [XW-1:0] off_x;
    logic [YW-1:0] off_y;

    // Frame boundary sits in vertical blanking, so offsets never move mid-picture.
    assign fb       = (h_cnt == 10'd0) && (v_cnt == 10'(V_ACTIVE));
    assign mode_chg = (state_t'(mode) != state);
    assign count_en = fb && run && !mode_chg;
    assign wrap     = count_en && (frame_cnt == FW'(TICK_FRAMES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_STATIC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (fb) begin
            state_next = state_t'(mode);
        end
    end

    always_comb begin
        clr    = 1'b0;
        step_x = 1'b0;
        step_y = 1'b0;
        tog_x  = 1'b0;
        if (fb && mode_chg) begin
            clr = 1'b1;
        end else begin
            case (state)
                S_PAN_H:  step_x = wrap;
                S_PAN_V:  step_y = wrap;
                S_TOGGLE: tog_x  = wrap;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (clr) begin
            frame_cnt <= '0;
        end else if (count_en) begin
            frame_cnt <= wrap ? '0 : frame_cnt + 1'b1;
        end
    end

    pan_offset_ctr #(
        .LIMIT (IMG_W),
        .STEP  (STEP_X),
        .W     (XW)
    ) u_pan_x (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .step  (step_x),
        .tog   (tog_x),
        .off   (off_x)
    );

    pan_offset_ctr #(
        .LIMIT (IMG_H),
        .STEP  (STEP_Y),
        .W     (YW)
    ) u_pan_y (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .step  (step_y),
        .tog   (1'b0),
        .off   (off_y)
    );

    logic [10:0]   sum_x;
    logic [10:0]   sum_y;
    logic [10:0]   wrap_x;
    logic [10:0]   wrap_y;
    logic [10:0]   fin_x;
    logic [10:0]   fin_y;
    logic          in_area;
    logic [XW-1:0] sx_r;
    logic [YW-1:0] sy_r;
    logic          v1;
    logic          v2;

    assign in_area = valid && (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
    assign sum_x   = 11'(h_cnt >> SCALE_SH) + 11'(off_x);
    assign sum_y   = 11'(v_cnt >> SCALE_SH) + 11'(off_y);
    assign wrap_x  = (sum_x >= 11'(IMG_W)) ? sum_x - 11'(IMG_W) : sum_x;
    assign wrap_y  = (sum_y >= 11'(IMG_H)) ? sum_y - 11'(IMG_H) : sum_y;

`ifdef VGA_VIEW_MIRROR_EN
    assign fin_x = hmir ? 11'(IMG_W - 1) - wrap_x : wrap_x;
    assign fin_y = vmir ? 11'(IMG_H - 1) - wrap_y : wrap_y;
`else
    logic unused_mirror;
    assign unused_mirror = hmir ^ vmir;
    assign fin_x = wrap_x;
    assign fin_y = wrap_y;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx_r <= '0;
            sy_r <= '0;
            v1   <= 1'b0;
        end else begin
            sx_r <= XW'(fin_x);
            sy_r <= YW'(fin_y);
            v1   <= in_area;
        end
    end

    logic [ADDR_W-1:0] lin_addr;

    assign lin_addr = ADDR_W'(sy_r) * ADDR_W'(IMG_W) + ADDR_W'(sx_r);

    // pix_valid trails pixel_addr by one cycle to line up with BRAM read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_addr <= '0;
            v2         <= 1'b0;
            pix_valid  <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            pixel_addr <= v1 ? lin_addr : '0;
            v2         <= v1;
            pix_valid  <= v2;
            frame_tick <= fb;
        end
    end

endmodule

// File: tb/tb_vga_view_addr_gen.sv
// tb/tb_vga_view_addr_gen.sv - scoreboard bench for vga_view_addr_gen with directed raster probes
module tb_vga_view_addr_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        valid;
    logic [1:0]  mode;
    logic        run;
    logic        hmir;
    logic        vmir;
    logic [16:0] pixel_addr;
    logic        pix_valid;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [16:0] addr;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        q[$];
    logic [16:0] prev_addr = '0;

`ifdef VGA_VIEW_MIRROR_EN
    localparam logic [16:0] MIR_00 = 17'd76799;
    localparam logic [16:0] MIR_22 = 17'd76478;
`else
    localparam logic [16:0] MIR_00 = 17'd0;
    localparam logic [16:0] MIR_22 = 17'd321;
`endif

    vga_view_addr_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .valid      (valid),
        .mode       (mode),
        .run        (run),
        .hmir       (hmir),
        .vmir       (vmir),
        .pixel_addr (pixel_addr),
        .pix_valid  (pix_valid),
        .frame_tick (frame_tick)
    );

    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && pix_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pix_valid: pix_valid=1 with no pending probe at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (prev_addr !== e.addr) begin
                    errors++;
                    $display("FAIL %s: pixel_addr=%0d expected %0d", e.name, prev_addr, e.addr);
                end
                checks++;
                if (cyc - e.cyc != 3) begin
                    errors++;
                    $display("FAIL %s_latency: pix_valid after %0d cycles expected 3", e.name, cyc - e.cyc);
                end
            end
        end
        prev_addr <= pixel_addr;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic probe(input string name, input int h, input int v, input logic [16:0] exp);
        exp_t e;
        @(posedge clk) #1;
        h_cnt = 10'(h);
        v_cnt = 10'(v);
        valid = 1'b1;
        e.addr = exp;
        e.cyc  = cyc;
        e.name = name;
        q.push_back(e);
        @(posedge clk) #1;
        valid = 1'b0;
        h_cnt = 10'd5;
        v_cnt = 10'd5;
        repeat (3) @(posedge clk);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            @(posedge clk) #1;
            h_cnt = 10'd0;
            v_cnt = 10'd480;
            valid = 1'b0;
            @(posedge clk) #1;
            h_cnt = 10'd5;
            v_cnt = 10'd5;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        h_cnt = 10'd5;
        v_cnt = 10'd5;
        valid = 1'b0;
        mode  = 2'd0;
        run   = 1'b1;
        hmir  = 1'b0;
        vmir  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_addr", 32'(pixel_addr), 32'd0);
        check("reset_pix_valid", 32'(pix_valid), 32'd0);
        check("reset_frame_tick", 32'(frame_tick), 32'd0);
        rst_n = 1'b1;

        // Reset asserted mid-line with the pipeline full
        @(posedge clk) #1;
        h_cnt = 10'd639;
        v_cnt = 10'd479;
        valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_addr", 32'(pixel_addr), 32'd76799);
        check("pre_reset_pix_valid", 32'(pix_valid), 32'd1);
        rst_n = 1'b0;
        valid = 1'b0;
        h_cnt = 10'd5;
        v_cnt = 10'd5;
        #1;
        check("async_reset_addr", 32'(pixel_addr), 32'd0);
        check("async_reset_pix_valid", 32'(pix_valid), 32'd0);
        check("async_reset_frame_tick", 32'(frame_tick), 32'd0);
        @(posedge clk) #1;
        rst_n = 1'b1;

        probe("static_00", 0, 0, 17'd0);
        probe("static_639_479", 639, 479, 17'd76799);
        probe("static_2_2", 2, 2, 17'd321);

        // frame_tick is fb registered: low during fb cycle, high the next
        @(posedge clk) #1;
        h_cnt = 10'd0;
        v_cnt = 10'd480;
        @(negedge clk);
        check("frame_tick_during_fb", 32'(frame_tick), 32'd0);
        @(posedge clk) #1;
        h_cnt = 10'd5;
        v_cnt = 10'd5;
        @(negedge clk);
        check("frame_tick_pulse", 32'(frame_tick), 32'd1);
        @(negedge clk);
        check("frame_tick_end", 32'(frame_tick), 32'd0);

        // Invalid cycle directly after a valid one zeroes the address
        @(posedge clk) #1;
        h_cnt = 10'd639;
        v_cnt = 10'd479;
        valid = 1'b1;
        begin
            exp_t e;
            e.addr = 17'd76799;
            e.cyc  = cyc;
            e.name = "valid_before_gap";
            q.push_back(e);
        end
        @(posedge clk) #1;
        valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("invalid_addr_zero", 32'(pixel_addr), 32'd0);
        h_cnt = 10'd5;
        v_cnt = 10'd5;
        repeat (3) @(posedge clk);

        // PAN_H: mode-change fb clears, then 319 steps of 4 frames each
        mode = 2'd1;
        frames(1);
        probe("panh_start", 0, 0, 17'd0);
        frames(1276);
        probe("panh_319_00", 0, 0, 17'd319);
        probe("panh_319_wrap", 2, 0, 17'd0);
        probe("panh_319_639", 639, 0, 17'd318);
        frames(3);
        probe("panh_hold_3", 0, 0, 17'd319);
        frames(1);
        probe("panh_wrap_00", 0, 0, 17'd0);
        probe("panh_wrap_2", 2, 0, 17'd1);

        // PAN_V for 10 counting frames: off_y=2, frame_cnt=2
        mode = 2'd2;
        frames(1);
        frames(10);
        probe("panv_00", 0, 0, 17'd640);
        probe("panv_wrap", 0, 479, 17'd320);
        mode = 2'd1;
        probe("switch_before_fb", 0, 0, 17'd640);
        frames(1);
        probe("switch_after_fb", 0, 0, 17'd0);
        frames(3);
        probe("switch_cnt_cleared", 0, 0, 17'd0);
        frames(1);
        probe("switch_first_step", 0, 0, 17'd1);

        // TOGGLE between 0 and IMG_W/2
        mode = 2'd3;
        frames(1);
        probe("toggle_start", 0, 0, 17'd0);
        probe("toggle_offy_zero", 0, 2, 17'd320);
        frames(4);
        probe("toggle_160", 0, 0, 17'd160);
        frames(4);
        probe("toggle_back_0", 0, 0, 17'd0);
        frames(4);
        probe("toggle_160_again", 0, 0, 17'd160);
        run = 1'b0;
        frames(10);
        probe("toggle_run0_hold", 0, 0, 17'd160);
        run = 1'b1;
        frames(4);
        probe("toggle_after_run", 0, 0, 17'd0);

        // Mirroring in STATIC
        mode = 2'd0;
        frames(1);
        hmir = 1'b1;
        vmir = 1'b1;
        probe("mirror_00", 0, 0, MIR_00);
        probe("mirror_2_2", 2, 2, MIR_22);
        hmir = 1'b0;
        vmir = 1'b0;
        probe("mirror_off", 2, 2, 17'd321);

        begin
            int t = 0;
            while (q.size() > 0 && t < 20) begin
                @(posedge clk);
                t++;
            end
        end
        check("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
